addr_seq: RTL

Parametrised operand-address sequencer for the 6502-style core. It turns the 3-bit addressing-mode field (`iax` encoding) plus index registers into a sequence of memory accesses, and returns the fetched operand or performs a store. It supports all eight group-01 modes, including pre-indexed indirect `(zp,x)`, a configurable direct page, wait-state handshaking and stores. It sits between the opcode decoder/register file and the memory port, and takes over operand addressing from the core's fixed sequencer.

---
 rtl/addr_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/addr_seq.sv
// addr_seq: operand-address sequencer turning an iax addressing mode plus index registers into memory accesses.
module addr_seq #(
  parameter int DW = 8,
  parameter logic [DW-1:0] ZP_PAGE = '0,
  parameter bit FIX_ON_WRITE = 1'b1
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic            wr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW-1:0]   idx_x,
  input  logic [DW-1:0]   idx_y,
  input  logic [2*DW-1:0] pc,
  output logic            pc_inc,
  output logic            mem_req,
  output logic            mem_we,
  output logic [2*DW-1:0] mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   rdata,
  output logic [2*DW-1:0] ea,
  output logic            page_cross
);
  typedef enum logic [2:0] {IDLE, LO, PLO, PHI, HI, FIX, DATA} state_t;
  localparam logic [2:0] M_IZX = 3'd0, M_ZP = 3'd1, M_IMM = 3'd2, M_AB = 3'd3,
                         M_IZY = 3'd4, M_ZPX = 3'd5, M_ABY = 3'd6, M_ABX = 3'd7;
  localparam logic [DW-1:0] ONE = 1;
  state_t state;
  logic [2:0] m;
  logic wr_q, cry;
  logic [DW-1:0] lo, hi, ptr, idx;
  logic [DW:0] isum;
  logic need_fix, indexed;
  logic [2*DW-1:0] data_addr;
  assign idx = (m == M_ABX) ? idx_x : idx_y;
  assign isum = {1'b0, lo} + {1'b0, idx};
  assign need_fix = isum[DW] | (wr_q & FIX_ON_WRITE);
  assign indexed = (m == M_IZY) || (m == M_ABY) || (m == M_ABX);
  // hi is already carry-corrected by FIX when DATA is reached
  always_comb
    data_addr = (m == M_IMM) ? pc :
                (m == M_ZP)  ? {ZP_PAGE, lo} :
                (m == M_ZPX) ? {ZP_PAGE, lo + idx_x} :
                indexed      ? {hi, isum[DW-1:0]} : {hi, lo};
  always_comb
    mem_addr = (state == PLO) ? {ZP_PAGE, ptr} :
               (state == PHI) ? {ZP_PAGE, ptr + ONE} :
               (state == DATA || state == FIX) ? data_addr : pc;
  assign mem_req = (state != IDLE) && (state != FIX);
  assign mem_we = (state == DATA) && wr_q;
  assign mem_wdata = wdata;
  assign pc_inc = mem_ready && (state == LO || state == HI || (state == DATA && m == M_IMM));
  always_ff @(posedge CLK) begin
    if (R) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      page_cross <= 1'b0;
      rdata <= '0;
      ea <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m <= mode;
          wr_q <= wr;
          busy <= 1'b1;
          state <= (mode == M_IMM) ? DATA : LO;
        end
        LO: if (mem_ready) begin
          lo <= mem_rdata;
          ptr <= (m == M_IZX) ? mem_rdata + idx_x : mem_rdata;
          state <= (m == M_ZP || m == M_ZPX) ? DATA : (m == M_IZX || m == M_IZY) ? PLO : HI;
        end
        PLO: if (mem_ready) begin
          lo <= mem_rdata;
          state <= PHI;
        end
        PHI: if (mem_ready) begin
          hi <= mem_rdata;
          cry <= isum[DW];
          state <= (m == M_IZY && need_fix) ? FIX : DATA;
        end
        HI: if (mem_ready) begin
          hi <= mem_rdata;
          cry <= isum[DW];
          state <= (m != M_AB && need_fix) ? FIX : DATA;
        end
        FIX: begin
          hi <= hi + {{(DW-1){1'b0}}, cry};
          state <= DATA;
        end
        DATA: if (mem_ready) begin
          if (!wr_q) rdata <= mem_rdata;
          ea <= data_addr;
          page_cross <= indexed & cry;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
